// File: rtl/lcd_output_stage.sv
// LCD output stage: pixel-tick divider, H/V timing, delay-matched sync/DE,
// overlay colour mux and backlight PWM for the panel pins.
module lcd_output_stage #(
  parameter int CLOCK_DIV  = 2,
  parameter int H_ACTIVE   = 800,
  parameter int H_FRONT    = 40,
  parameter int H_SYNC     = 48,
  parameter int H_BACK     = 40,
  parameter int V_ACTIVE   = 480,
  parameter int V_FRONT    = 13,
  parameter int V_SYNC     = 3,
  parameter int V_BACK     = 29,
  parameter int PIPE_DELAY = 1,
  parameter int COLOR_BITS = 8,
  parameter int PWM_BITS   = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  display_enable,
  input  logic [PWM_BITS-1:0]   backlight_level,
  output logic [9:0]            x,
  output logic [9:0]            y,
  output logic                  pixel_tick,
  output logic                  next_frame,
  input  logic [COLOR_BITS-1:0] fb_red,
  input  logic [COLOR_BITS-1:0] fb_green,
  input  logic [COLOR_BITS-1:0] fb_blue,
  input  logic                  overlay_bw,
  output logic [COLOR_BITS-1:0] lcd_red,
  output logic [COLOR_BITS-1:0] lcd_green,
  output logic [COLOR_BITS-1:0] lcd_blue,
  output logic                  lcd_hs_n,
  output logic                  lcd_vs_n,
  output logic                  lcd_de,
  output logic                  lcd_clk,
  output logic                  lcd_display_on,
  output logic                  lcd_backlight
);
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int DW      = $clog2(CLOCK_DIV);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLOCK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLOCK_DIV / 2);
  localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT        = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_START = 11'(H_ACTIVE + H_FRONT);
  localparam logic [10:0] H_SYNC_END   = 11'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_LAST       = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_ACT        = 11'(V_ACTIVE);
  localparam logic [10:0] V_ACT_LAST   = 11'(V_ACTIVE - 1);
  localparam logic [10:0] V_SYNC_START = 11'(V_ACTIVE + V_FRONT);
  localparam logic [10:0] V_SYNC_END   = 11'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [DW-1:0]       div_cnt;
  logic [10:0]         h;
  logic [10:0]         v;
  logic [2:0]          raw_ctl;  // {de, hs, vs}, sync active-high
  logic [2:0]          dly_ctl;
  logic                shown;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] pwm_lvl;
  logic [PWM_BITS-1:0] lvl_eff;

  assign pixel_tick = (div_cnt == DIV_LAST);
  assign lcd_clk    = (div_cnt >= DIV_HALF);
  assign x          = h[9:0];
  assign y          = v[9:0];
  assign next_frame = pixel_tick && (h == H_LAST) && (v == V_ACT_LAST);
  assign raw_ctl    = {(h < H_ACT) && (v < V_ACT),
                       (h >= H_SYNC_START) && (h < H_SYNC_END),
                       (v >= V_SYNC_START) && (v < V_SYNC_END)};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h <= '0;
      v <= '0;
    end else if (pixel_tick) begin
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? 11'd0 : v + 11'd1;
      end else begin
        h <= h + 11'd1;
      end
    end
  end

  // Delay raw controls so they line up with colour arriving from the frame buffer.
  generate
    if (PIPE_DELAY == 0) begin : g_no_delay
      assign dly_ctl = raw_ctl;
    end else begin : g_delay
      logic [2:0] sr [PIPE_DELAY];
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < PIPE_DELAY; i++) sr[i] <= '0;
        end else if (pixel_tick) begin
          sr[0] <= raw_ctl;
          for (int i = 1; i < PIPE_DELAY; i++) sr[i] <= sr[i-1];
        end
      end
      assign dly_ctl = sr[PIPE_DELAY-1];
    end
  endgenerate

  assign shown = dly_ctl[2] && display_enable;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lcd_red   <= '0;
      lcd_green <= '0;
      lcd_blue  <= '0;
      lcd_hs_n  <= 1'b1;
      lcd_vs_n  <= 1'b1;
      lcd_de    <= 1'b0;
    end else if (pixel_tick) begin
      lcd_hs_n  <= ~dly_ctl[1];
      lcd_vs_n  <= ~dly_ctl[0];
      lcd_de    <= shown;
      lcd_red   <= !shown ? '0 : (overlay_bw ? '1 : fb_red);
      lcd_green <= !shown ? '0 : (overlay_bw ? '1 : fb_green);
      lcd_blue  <= !shown ? '0 : (overlay_bw ? '1 : fb_blue);
    end
  end

  // A new level is picked up only at the start of a PWM period.
  assign lvl_eff = (pwm_cnt == '0) ? backlight_level : pwm_lvl;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pwm_cnt        <= '0;
      pwm_lvl        <= '0;
      lcd_backlight  <= 1'b0;
      lcd_display_on <= 1'b0;
    end else begin
      pwm_cnt        <= pwm_cnt + 1'b1;
      pwm_lvl        <= lvl_eff;
      lcd_backlight  <= (&lvl_eff) || (pwm_cnt < lvl_eff);
      lcd_display_on <= display_enable;
    end
  end
endmodule

// File: tb/tb_lcd_output_stage.sv
// Randomised bench for lcd_output_stage: a tick-index reference model feeds
// expectation queues that a monitor drains as the DUT presents cycles/ticks.
module tb_lcd_output_stage;
  localparam int CDIV = 4;
  localparam int HA = 16, HF = 3, HS = 4, HB = 5;
  localparam int VA = 10, VF = 2, VS = 2, VB = 3;
  localparam int PD = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int RST_AT = 3 * HT * VT * CDIV + (5 * HT + 10) * CDIV + 1;
  localparam int RUN_CYCLES = 12000;

  typedef struct packed {
    logic       tick;
    logic [9:0] x;
    logic [9:0] y;
    logic       nf;
    logic       lclk;
  } tim_t;

  typedef struct packed {
    logic bl;
    logic don;
  } misc_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       hs_n;
    logic       vs_n;
    logic       de;
  } pix_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       display_enable = 1'b0;
  logic [7:0] backlight_level = '0;
  logic [9:0] x, y;
  logic       pixel_tick, next_frame;
  logic [7:0] fb_red = '0, fb_green = '0, fb_blue = '0;
  logic       overlay_bw = 1'b0;
  logic [7:0] lcd_red, lcd_green, lcd_blue;
  logic       lcd_hs_n, lcd_vs_n, lcd_de, lcd_clk, lcd_display_on, lcd_backlight;

  lcd_output_stage #(
    .CLOCK_DIV(CDIV), .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .PIPE_DELAY(PD), .COLOR_BITS(8), .PWM_BITS(8)
  ) dut (
    .clock(clock), .reset(reset), .display_enable(display_enable),
    .backlight_level(backlight_level), .x(x), .y(y),
    .pixel_tick(pixel_tick), .next_frame(next_frame),
    .fb_red(fb_red), .fb_green(fb_green), .fb_blue(fb_blue), .overlay_bw(overlay_bw),
    .lcd_red(lcd_red), .lcd_green(lcd_green), .lcd_blue(lcd_blue),
    .lcd_hs_n(lcd_hs_n), .lcd_vs_n(lcd_vs_n), .lcd_de(lcd_de), .lcd_clk(lcd_clk),
    .lcd_display_on(lcd_display_on), .lcd_backlight(lcd_backlight)
  );

  always #5 clock = ~clock;

  int    pass_cnt = 0;
  int    tot_cnt  = 0;
  tim_t  q_tim[$];
  misc_t q_misc[$];
  pix_t  q_pix[$];
  logic  mon_en = 1'b0;
  int    c = 0;
  int    g = 0;
  logic [7:0] per_lvl = '0;
  logic  bl_next = 1'b0;
  logic  don_next = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    tot_cnt++;
    if (act === want) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
  endtask

  task automatic missing(input string nm);
    tot_cnt++;
    $display("FAIL %s: DUT output with no expectation queued at %0t", nm, $time);
  endtask

  function automatic int h_of(input int m);
    return m % HT;
  endfunction

  function automatic int v_of(input int m);
    return (m / HT) % VT;
  endfunction

  task automatic check_reset(input string nm);
    chk(nm, {pixel_tick, next_frame, x, y, lcd_red, lcd_green, lcd_blue,
             lcd_hs_n, lcd_vs_n, lcd_de, lcd_clk, lcd_display_on, lcd_backlight},
            {1'b0, 1'b0, 10'd0, 10'd0, 24'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
  endtask

  task automatic restart();
    c = 0;
    per_lvl = '0;
    bl_next = 1'b0;
    don_next = 1'b0;
    q_tim.delete();
    q_misc.delete();
    q_pix.delete();
  endtask

  // Drive one cycle of stimulus and queue what the DUT should show for it.
  task automatic step();
    int m, ph, kh, kv;
    logic en, ov, de_d, hs_d, vs_d;
    logic [7:0] lvl, fr, fg, fbl;
    tim_t t;
    misc_t mi;
    pix_t p;
    if (g < 1000) lvl = 8'd64;
    else if (g < 2000) lvl = 8'd255;
    else if (g < 3000) lvl = 8'd0;
    else if (g % 300 == 0) lvl = 8'($urandom);
    else lvl = backlight_level;
    en = !((g >= 2500 && g < 3500) || (g >= 9000 && g < 9600));
    m  = c / CDIV;
    ph = c % CDIV;
    fr  = (m >= PD) ? 8'(h_of(m - PD)) : 8'($urandom);
    fg  = 8'($urandom);
    fbl = 8'($urandom);
    ov  = ($urandom_range(0, 3) == 0);
    display_enable  = en;
    backlight_level = lvl;
    fb_red = fr; fb_green = fg; fb_blue = fbl;
    overlay_bw = ov;

    t.tick = (ph == CDIV - 1);
    t.x    = 10'(h_of(m));
    t.y    = 10'(v_of(m));
    t.nf   = t.tick && (h_of(m) == HT - 1) && (v_of(m) == VA - 1);
    t.lclk = (ph >= CDIV / 2);
    q_tim.push_back(t);
    mi.bl  = bl_next;
    mi.don = don_next;
    q_misc.push_back(mi);

    if (c % 256 == 0) per_lvl = lvl;
    bl_next  = (per_lvl == 8'hff) || ((c % 256) < int'(per_lvl));
    don_next = en;

    if (t.tick) begin
      de_d = 1'b0; hs_d = 1'b0; vs_d = 1'b0;
      if (m >= PD) begin
        kh = h_of(m - PD);
        kv = v_of(m - PD);
        de_d = (kh < HA) && (kv < VA);
        hs_d = (kh >= HA + HF) && (kh < HA + HF + HS);
        vs_d = (kv >= VA + VF) && (kv < VA + VF + VS);
      end
      p.de   = de_d && en;
      p.hs_n = !hs_d;
      p.vs_n = !vs_d;
      p.r = !p.de ? 8'h00 : (ov ? 8'hff : fr);
      p.g = !p.de ? 8'h00 : (ov ? 8'hff : fg);
      p.b = !p.de ? 8'h00 : (ov ? 8'hff : fbl);
      q_pix.push_back(p);
    end
    c++;
    g++;
  endtask

  // Monitor: every cycle compares free-running outputs; after each DUT tick
  // compares the registered panel outputs.
  initial begin
    logic prev_tick;
    tim_t ta, tw;
    misc_t ma, mw;
    pix_t pa, pw;
    prev_tick = 1'b0;
    forever begin
      @(negedge clock);
      #2;
      if (!mon_en) begin
        prev_tick = 1'b0;
      end else begin
        if (q_tim.size() == 0) missing("timing_queue");
        else begin
          tw = q_tim.pop_front();
          ta = '{tick: pixel_tick, x: x, y: y, nf: next_frame, lclk: lcd_clk};
          chk("timing", ta, tw);
        end
        if (q_misc.size() == 0) missing("backlight_queue");
        else begin
          mw = q_misc.pop_front();
          ma = '{bl: lcd_backlight, don: lcd_display_on};
          chk("backlight_dispon", ma, mw);
        end
        if (prev_tick) begin
          if (q_pix.size() == 0) missing("pixel_queue");
          else begin
            pw = q_pix.pop_front();
            pa = '{r: lcd_red, g: lcd_green, b: lcd_blue,
                   hs_n: lcd_hs_n, vs_n: lcd_vs_n, de: lcd_de};
            chk("pixel", pa, pw);
          end
        end
        prev_tick = pixel_tick;
      end
    end
  end

  initial begin
    logic did_rst;
    did_rst = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 check_reset("reset_initial");
    @(negedge clock);
    reset = 1'b0;
    restart();
    mon_en = 1'b1;
    step();
    while (g < RUN_CYCLES) begin
      @(negedge clock);
      if (c == RST_AT && !did_rst) begin
        did_rst = 1'b1;
        mon_en = 1'b0;
        #1 reset = 1'b1;
        #1 check_reset("reset_midframe");
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        restart();
        mon_en = 1'b1;
      end
      step();
    end
    #3 mon_en = 1'b0;
    chk("leftover_cycles", 64'(q_tim.size()), 64'd0);
    chk("leftover_ticks", 64'(q_pix.size() > 1), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
